// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cipher_pkg
//  Purpose  : Shared FSM encoding, LFSR constants and step function for the
//             keystream cipher stage.
//  Revision : 1.0 - initial release
// ============================================================================
package cipher_pkg;

   localparam int LFSR_W = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

   localparam int TAP_A = 0;
   localparam int TAP_B = 2;
   localparam int TAP_C = 3;
   localparam int TAP_D = 4;
   localparam int TAP_E = 7;

   // Left shift with the XOR of the tap bits fed into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_E] ^ s[TAP_D] ^ s[TAP_C] ^ s[TAP_B] ^ s[TAP_A]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/keystream_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : keystream_lfsr
//  Purpose  : 8-bit Fibonacci LFSR register with synchronous load and step.
//  Revision : 1.0 - initial release
// ============================================================================
module keystream_lfsr
   import cipher_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] r_state;

   // Load has priority: a frame start replaces the state with the stepped seed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= LFSR_RESET;
      end else if (load) begin
         r_state <= load_val;
      end else if (advance) begin
         r_state <= lfsr_step(r_state);
      end
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/xor_keystream_stage.sv
`default_nettype none
// ============================================================================
//  Module   : xor_keystream_stage
//  Purpose  : Streaming XOR cipher stage with per-frame LFSR keystream and a
//             one-deep output register.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_keystream_stage
   import cipher_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  seed_load,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic                  busy
);

   logic [1:0]            r_state;
   logic [LFSR_W-1:0]     r_seed;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_last;
   logic [CNT_WIDTH-1:0]  r_frame_cnt;

   logic                  w_idle;
   logic                  w_in_ready;
   logic                  w_in_xfer;
   logic                  w_out_xfer;
   logic [LFSR_W-1:0]     w_seed_in;
   logic [LFSR_W-1:0]     w_seed_eff;
   logic [LFSR_W-1:0]     w_ks;
   logic [LFSR_W-1:0]     w_lfsr;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_in_ready = (r_state != ST_DRAIN) && (!r_out_valid || out_ready);
   assign w_in_xfer  = in_valid && w_in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   // A seed loaded in the same cycle as the first byte is used for that byte.
   assign w_seed_in  = LFSR_W'(seed);
   assign w_seed_eff = (w_idle && seed_load)
                       ? ((w_seed_in == '0) ? LFSR_RESET : w_seed_in)
                       : r_seed;
   assign w_ks       = w_idle ? w_seed_eff : w_lfsr;

   keystream_lfsr u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .advance  (w_in_xfer && !w_idle),
      .load     (w_in_xfer && w_idle),
      .load_val (lfsr_step(w_seed_eff)),
      .state    (w_lfsr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seed <= LFSR_RESET;
      end else if (w_idle && seed_load) begin
         r_seed <= w_seed_eff;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_in_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data ^ DATA_WIDTH'(w_ks);
         r_out_last  <= in_last;
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_cnt <= '0;
      end else if (w_in_xfer) begin
         if (w_idle) begin
            r_frame_cnt <= CNT_WIDTH'(1);
         end else if (r_frame_cnt != '1) begin
            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_in_xfer) begin
                  r_state <= in_last ? ST_DRAIN : ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_in_xfer && in_last) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_out_xfer && r_out_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign frame_cnt = r_frame_cnt;
   assign busy      = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_xor_keystream_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_keystream_stage
//  Purpose  : Directed self-checking bench for xor_keystream_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_keystream_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [7:0]  seed;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [15:0] frame_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] tb_in    [64];
   logic [7:0] tb_out   [64];
   logic       tb_olast [64];
   logic [7:0] tb_plain [64];

   xor_keystream_stage #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ks_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[4] ^ s[3] ^ s[2] ^ s[0]};
   endfunction

   // Streams tb_in[0..n-1] with out_ready held high and captures every output.
   task automatic stream_frame(input int n, input bit ld, input logic [7:0] sd);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      out_ready = 1'b1;
      while (got < n && cyc < n + 20) begin
         @(posedge clk); #1;
         in_valid  = (sent < n);
         in_data   = (sent < n) ? tb_in[sent] : 8'h00;
         in_last   = (sent == n - 1);
         seed_load = ld;
         seed      = (sent == 0) ? sd : ~sd;
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            tb_out[got]   = out_data;
            tb_olast[got] = out_last;
            got++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      seed_load = 1'b0;
      seed      = 8'h00;
      if (got < n) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got %0d outputs, required %0d", got, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; seed_load = 1'b0; seed = 8'h00;
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: valid=%b data=%h last=%b, required 0/00/0", out_valid, out_data, out_last);
      end
      checks++;
      if (frame_cnt !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt_busy: frame_cnt=%0d busy=%b, required 0/0", frame_cnt, busy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      checks++;
      if (dut.u_lfsr.state !== 8'h01) begin
         errors++;
         $display("FAIL reset_lfsr: got %h, required 01", dut.u_lfsr.state);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic_frame;
      logic [7:0] exp [4];
      exp = '{8'h01, 8'h03, 8'h07, 8'h0E};
      for (int i = 0; i < 4; i++) tb_in[i] = 8'h00;
      stream_frame(4, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tb_out[i] !== exp[i] || tb_olast[i] !== (i == 3)) begin
            errors++;
            $display("FAIL basic_byte%0d: data=%h last=%b, required %h/%b", i, tb_out[i], tb_olast[i], exp[i], (i == 3));
         end
      end
      checks++;
      if (frame_cnt !== 16'd4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_cnt_busy: frame_cnt=%0d busy=%b, required 4/0", frame_cnt, busy);
      end
   endtask

   task automatic test_seed_a5;
      @(posedge clk); #1;
      seed_load = 1'b1; seed = 8'hA5; in_valid = 1'b0;
      @(posedge clk); #1;
      seed_load = 1'b0; seed = 8'h00;
      tb_in[0] = 8'h5A;
      stream_frame(1, 1'b0, 8'h00);
      checks++;
      if (tb_out[0] !== 8'hFF || tb_olast[0] !== 1'b1) begin
         errors++;
         $display("FAIL seed_a5_byte: data=%h last=%b, required ff/1", tb_out[0], tb_olast[0]);
      end
      checks++;
      if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL seed_a5_done: busy=%b frame_cnt=%0d, required 0/1", busy, frame_cnt);
      end
   endtask

   task automatic test_stall;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_first_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_data = 8'h22;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hB4 || dut.u_lfsr.state !== 8'h4B) begin
            errors++;
            $display("FAIL stall_cycle%0d: in_ready=%b out_valid=%b out_data=%h lfsr=%h, required 0/1/b4/4b",
                     i, in_ready, out_valid, out_data, dut.u_lfsr.state);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_passthrough: in_ready=%b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_data = 8'h33; in_last = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h69 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_bubble: valid=%b data=%h last=%b, required 1/69/0", out_valid, out_data, out_last);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      checks++;
      if (out_data !== 8'hA5 || out_last !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: data=%h last=%b busy=%b in_ready=%b, required a5/1/1/0", out_data, out_last, busy, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'd3) begin
         errors++;
         $display("FAIL stall_done: busy=%b valid=%b frame_cnt=%0d, required 0/0/3", busy, out_valid, frame_cnt);
      end
   endtask

   task automatic test_zero_seed;
      tb_in[0] = 8'h3C;
      stream_frame(1, 1'b1, 8'h00);
      checks++;
      if (tb_out[0] !== 8'h3D) begin
         errors++;
         $display("FAIL zero_seed: data=%h, required 3d", tb_out[0]);
      end
   endtask

   task automatic test_roundtrip;
      logic [7:0] ks;
      int bad_ct = 0;
      int bad_pt = 0;
      for (int i = 0; i < 64; i++) begin
         tb_in[i]    = 8'($urandom_range(0, 255));
         tb_plain[i] = tb_in[i];
      end
      stream_frame(64, 1'b1, 8'h37);
      ks = 8'h37;
      for (int i = 0; i < 64; i++) begin
         if (tb_out[i] !== (tb_plain[i] ^ ks) || tb_olast[i] !== (i == 63)) bad_ct++;
         ks = ks_next(ks);
      end
      checks++;
      if (bad_ct != 0) begin
         errors++;
         $display("FAIL roundtrip_cipher: %0d bad bytes, required 0", bad_ct);
      end
      checks++;
      if (frame_cnt !== 16'd64) begin
         errors++;
         $display("FAIL roundtrip_cnt: frame_cnt=%0d, required 64", frame_cnt);
      end
      for (int i = 0; i < 64; i++) tb_in[i] = tb_out[i];
      stream_frame(64, 1'b0, 8'h00);
      for (int i = 0; i < 64; i++) begin
         if (tb_out[i] !== tb_plain[i]) bad_pt++;
      end
      checks++;
      if (bad_pt != 0) begin
         errors++;
         $display("FAIL roundtrip_plain: %0d bad bytes, required 0", bad_pt);
      end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup: busy=%b out_valid=%b, required 1/1", busy, out_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midreset_clear: valid=%b data=%h busy=%b frame_cnt=%0d, required 0/00/0/0",
                  out_valid, out_data, busy, frame_cnt);
      end
      checks++;
      if (dut.u_lfsr.state !== 8'h01) begin
         errors++;
         $display("FAIL midreset_lfsr: got %h, required 01", dut.u_lfsr.state);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      tb_in[0] = 8'h00;
      stream_frame(1, 1'b0, 8'h00);
      checks++;
      if (tb_out[0] !== 8'h01) begin
         errors++;
         $display("FAIL midreset_seed: first keystream=%h, required 01", tb_out[0]);
      end
   endtask

   initial begin
      test_reset;
      test_basic_frame;
      test_seed_a5;
      test_stall;
      test_zero_seed;
      test_roundtrip;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
